// File: rtl/edge_capture.sv
// Multi-channel synchronise / glitch-filter / edge-capture with sticky pending flags and masked irq; filter built only with EDGE_CAPTURE_FILTER_EN.
// Latency: level SYNC_STAGES+filter_len edges after input, pulse +1, pending +2, irq +3; no backpressure, clear is level-sensitive.
module edge_capture #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_BITS = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [WIDTH-1:0]       in,
   input  logic [WIDTH-1:0]       rise_en,
   input  logic [WIDTH-1:0]       fall_en,
   input  logic [FILTER_BITS-1:0] filter_len,
   input  logic [WIDTH-1:0]       clear,
   input  logic [WIDTH-1:0]       irq_mask,
   output logic [WIDTH-1:0]       level,
   output logic [WIDTH-1:0]       pulse,
   output logic [WIDTH-1:0]       pending,
   output logic                   irq
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] pulse_q, pulse_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic             irq_q, irq_d;

   assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_CAPTURE_FILTER_EN
   logic [FILTER_BITS-1:0] cnt_q [WIDTH];
   logic [FILTER_BITS-1:0] cnt_d [WIDTH];

   // >= rather than == so a filter_len lowered mid-count still accepts
   always_comb begin
      level_d = level_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (s[i] != level_q[i]) begin
            if (cnt_q[i] >= filter_len) level_d[i] = s[i];
            else                        cnt_d[i]   = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (!reset_n) cnt_q[i] <= '0;
         else          cnt_q[i] <= cnt_d[i];
      end
   end
`else
   logic unused_filter_len;
   assign unused_filter_len = ^filter_len;
   assign level_d = s;
`endif

   // Edges come from level history only, so enable changes alone never pulse
   assign pulse_d   = (rise_en & level_q & ~prev_q) | (fall_en & ~level_q & prev_q);
   assign pending_d = (pending_q & ~clear) | pulse_q;
   assign irq_d     = |(pending_q & irq_mask);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         level_q   <= '0;
         prev_q    <= '0;
         pulse_q   <= '0;
         pending_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         sync_q[0] <= in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         level_q   <= level_d;
         prev_q    <= level_q;
         pulse_q   <= pulse_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
      end
   end

   assign level   = level_q;
   assign pulse   = pulse_q;
   assign pending = pending_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_edge_capture.sv
// Table-driven and hand-sequenced checks of edge_capture with an expected-value queue.
module tb_edge_capture;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] in_s, rise_en, fall_en, clear, irq_mask;
   logic [3:0] filter_len;
   logic [7:0] level, pulse, pending;
   logic       irq;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic       rst_n;
      logic [7:0] in, rise, fall, clr, mask;
      logic [7:0] lvl, pls, pnd;
      logic       irq;
   } vec_t;

   typedef struct {
      logic [7:0] lvl, pls, pnd;
      logic       irq;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];

   edge_capture #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_BITS(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in         (in_s),
      .rise_en    (rise_en),
      .fall_en    (fall_en),
      .filter_len (filter_len),
      .clear      (clear),
      .irq_mask   (irq_mask),
      .level      (level),
      .pulse      (pulse),
      .pending    (pending),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic r, input logic [7:0] i, input logic [7:0] ri,
                               input logic [7:0] fa, input logic [7:0] cl, input logic [7:0] mk,
                               input logic [7:0] lv, input logic [7:0] pl, input logic [7:0] pn,
                               input logic iq);
      vec_t v;
      v.rst_n = r; v.in = i; v.rise = ri; v.fall = fa; v.clr = cl; v.mask = mk;
      v.lvl = lv; v.pls = pl; v.pnd = pn; v.irq = iq;
      tbl.push_back(v);
   endfunction

   initial begin
      int   got;
      int   pcnt;
      int   lvl_t;
      int   pls_t;
      logic [7:0] acc;
      exp_t e;

      reset_n = 1'b0; in_s = 8'h00; rise_en = 8'h00; fall_en = 8'h00;
      clear = 8'h00; irq_mask = 8'h00; filter_len = 4'd0;

      // Reset with inputs high, then the release edge sequence
      add(0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
      add(0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
      add(0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
      add(1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
      add(1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
      add(1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
      add(1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0);
      add(1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 0);
      add(1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 1);
      add(1, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1);
      add(1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
      // ch0 rise only, ch1 both, ch2 neither: fall, rise, fall
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h02, 8'h00, 0);
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h02, 0);
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h02, 1);
      add(1, 8'h07, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h02, 1);
      add(1, 8'h07, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h02, 1);
      add(1, 8'h07, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h07, 8'h00, 8'h02, 1);
      add(1, 8'h07, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h07, 8'h03, 8'h02, 1);
      add(1, 8'h07, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h07, 8'h00, 8'h03, 1);
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h07, 8'h00, 8'h03, 1);
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h07, 8'h00, 8'h03, 1);
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h03, 1);
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h02, 8'h03, 1);
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h03, 1);
      add(1, 8'h00, 8'h03, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1);
      add(1, 8'h00, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0);

      #2;
      for (int r = 0; r < tbl.size(); r++) begin
         reset_n = tbl[r].rst_n; in_s = tbl[r].in; rise_en = tbl[r].rise;
         fall_en = tbl[r].fall; clear = tbl[r].clr; irq_mask = tbl[r].mask;
         e.lvl = tbl[r].lvl; e.pls = tbl[r].pls; e.pnd = tbl[r].pnd; e.irq = tbl[r].irq;
         exp_q.push_back(e);
         tick();
         e = exp_q.pop_front();
         chk($sformatf("row%0d_level", r),   {24'd0, level},   {24'd0, e.lvl});
         chk($sformatf("row%0d_pulse", r),   {24'd0, pulse},   {24'd0, e.pls});
         chk($sformatf("row%0d_pending", r), {24'd0, pending}, {24'd0, e.pnd});
         chk($sformatf("row%0d_irq", r),     {31'd0, irq},     {31'd0, e.irq});
      end

      // Set/clear collision on ch3
      rise_en = 8'h08; fall_en = 8'h00; irq_mask = 8'h00; clear = 8'h00;
      in_s = 8'h08;
      got = 0;
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (pulse[3]) begin got = t; break; end
      end
      chk("collision_pulse_latency", got, 4);
      clear = 8'h08;
      tick();
      chk("collision_pending_set_wins", {31'd0, pending[3]}, 32'd1);
      tick();
      chk("collision_pending_cleared", {31'd0, pending[3]}, 32'd0);
      clear = 8'h00;

      // Interrupt masking with pending = 05
      rise_en = 8'h05; irq_mask = 8'h02; in_s = 8'h0D;
      for (int t = 0; t < 6; t++) tick();
      chk("mask_pending", {24'd0, pending}, 32'h05);
      chk("mask_irq_off", {31'd0, irq}, 32'd0);
      irq_mask = 8'h04;
      tick();
      chk("mask_irq_on", {31'd0, irq}, 32'd1);
      clear = 8'h04;
      tick();
      clear = 8'h00;
      chk("mask_clear_pending", {24'd0, pending}, 32'h01);
      tick();
      chk("mask_clear_irq", {31'd0, irq}, 32'd0);

      // Enable change on a stable high level
      rise_en = 8'h00; fall_en = 8'h00; in_s = 8'h1D;
      for (int t = 0; t < 5; t++) tick();
      chk("mode_level_high", {24'd0, level}, 32'h1D);
      rise_en = 8'h10;
      acc = 8'h00;
      for (int t = 0; t < 5; t++) begin tick(); acc = acc | pulse; end
      chk("mode_no_pulse", {24'd0, acc}, 32'h00);

      // Reset while a change is still in flight
`ifdef EDGE_CAPTURE_FILTER_EN
      filter_len = 4'd3;
`endif
      rise_en = 8'hFF; fall_en = 8'hFF; in_s = 8'h00;
      tick(); tick();
      reset_n = 1'b0;
      tick(); tick();
      chk("midrst_level", {24'd0, level}, 32'h00);
      chk("midrst_pulse", {24'd0, pulse}, 32'h00);
      chk("midrst_pending", {24'd0, pending}, 32'h00);
      chk("midrst_irq", {31'd0, irq}, 32'd0);
      reset_n = 1'b1;
      acc = 8'h00;
      for (int t = 0; t < 8; t++) begin tick(); acc = acc | pulse | level | pending; end
      chk("midrst_quiet_after", {24'd0, acc}, 32'h00);

`ifdef EDGE_CAPTURE_FILTER_EN
      // Glitch filter at filter_len = 3
      filter_len = 4'd3; rise_en = 8'h01; fall_en = 8'h00;
      in_s = 8'h01;
      for (int t = 0; t < 3; t++) tick();
      in_s = 8'h00;
      acc = 8'h00;
      for (int t = 0; t < 10; t++) begin tick(); acc = acc | level | pulse; end
      chk("filter_glitch_rejected", {24'd0, acc}, 32'h00);
      in_s = 8'h01;
      lvl_t = 0; pls_t = 0; pcnt = 0;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (t == 4) in_s = 8'h00;
         if (level[0] && lvl_t == 0) lvl_t = t;
         if (pulse[0]) begin pcnt++; if (pls_t == 0) pls_t = t; end
      end
      chk("filter_level_edge", lvl_t, 6);
      chk("filter_pulse_edge", pls_t, 7);
      chk("filter_pulse_count", pcnt, 1);
`endif

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/edge_capture.md
# edge_capture

Multi-channel edge capture unit, the parametrised successor to the single-bit edge detector. Each of `WIDTH` asynchronous inputs is synchronised, optionally glitch-filtered, and edge-detected per channel as rising, falling or both. Each detected edge produces a one-cycle pulse and sets a sticky pending flag that software clears. A maskable interrupt request is raised while any pending flag is enabled. The block sits between GPIO/pad inputs and the SoC peripheral register file.

## Interface
Parameters:
- `WIDTH`, 8: number of channels.
- `SYNC_STAGES`, 2: synchroniser flop count, minimum 2.
- `FILTER_BITS`, 4: glitch-filter counter width; only used with the filter compiled in.

Ports:
- `clk` input 1: the single clock. All state is updated on its rising edge.
- `reset_n` input 1: reset, synchronous and active-low.
- `in` input WIDTH: asynchronous channel inputs.
- `rise_en` input WIDTH: per channel, detect rising edges.
- `fall_en` input WIDTH: per channel, detect falling edges.
- `filter_len` input FILTER_BITS: number of extra stable cycles required before a change is accepted. Shared by all channels.
- `clear` input WIDTH: per channel, clear the pending flag. Level-sensitive.
- `irq_mask` input WIDTH: per channel, 1 enables that channel's contribution to `irq`.
- `level` output WIDTH: filtered, synchronised level.
- `pulse` output WIDTH: one-cycle edge pulse.
- `pending` output WIDTH: sticky edge flags.
- `irq` output 1: interrupt request.

## Operation
- **Reset.** While `reset_n` = 0 at a clock edge, all state clears: synchroniser flops, filter counters, `level`, `pulse`, `pending` and `irq` all go to 0.
- **Synchroniser.** `in[i]` passes through `SYNC_STAGES` flops. The last flop's output is `s[i]`.
- **Filter, per channel.**
  - Counter `cnt[i]` is `FILTER_BITS` wide.
  - If `s[i]` equals `level[i]`: `cnt[i]` is set to 0.
  - Else, if `cnt[i]` ≥ `filter_len`: `level[i]` takes the value of `s[i]` and `cnt[i]` is set to 0.
  - Else: `cnt[i]` increments.
  - The result is that a change is accepted after `filter_len`+1 consecutive mismatching cycles. A mismatch that ends early discards the count.
  - The ≥ comparison guarantees acceptance if `filter_len` is lowered mid-count.
  - The counter never wraps, because it is bounded by `filter_len`.
- **Edge detection.**
  - `pulse[i]` is registered. It is 1 on exactly the cycle after `level[i]` changes, when the change is 0→1 and `rise_en[i]`=1, or 1→0 and `fall_en[i]`=1. Otherwise it is 0.
  - Edges are derived from `level` only. Changing `rise_en` or `fall_en` never creates a pulse by itself; the new mode applies to the next `level` change.
  - With both enables at 0 the channel still tracks `level` but never pulses.
- **Pending flags.**
  - `pending[i]` is set by `pulse[i]` and cleared by `clear[i]`.
  - When `pulse[i]` and `clear[i]` occur in the same cycle, set wins and no event is lost.
  - Holding `clear[i]`=1 keeps the flag clear except on cycles where `pulse[i]`=1.
- **Interrupt.** `irq` is registered: `irq` = OR over `pending & irq_mask`, one cycle after `pending` updates. Masking does not alter `pending`.
- **Input high at reset release.** `level` starts at 0, so an input held high at release produces a rising edge after the normal latency. This is intended.

## Timing
Take `in[i]` to change and stay stable before clock edge k.
- `s[i]` changes after edge k+`SYNC_STAGES`-1.
- `level[i]` changes after edge k+`SYNC_STAGES`+`filter_len`.
  - Without the filter compiled in, it changes after edge k+`SYNC_STAGES`.
- `pulse[i]` is high for the one cycle after edge k+`SYNC_STAGES`+`filter_len`+1.
- `pending[i]` is set after edge k+`SYNC_STAGES`+`filter_len`+2.
- `irq` follows one edge later.
- `clear[i]` sampled at edge m takes effect after edge m, so `pending[i]` reads 0 from then on. `irq` drops one edge later if no other masked-in flag is set.
- Back-to-back accepted changes on one channel are spaced at least `filter_len`+1 cycles apart, so pulses on a channel are never adjacent when `filter_len` ≥ 1.

## Configuration
- `EDGE_CAPTURE_FILTER_EN` defined:
  - The glitch filter and `cnt` registers are present.
  - `filter_len` is used as described in Operation.
- Not defined:
  - No counters are built.
  - `level[i]` is `s[i]` registered one cycle, i.e. behaviour equals `filter_len`=0.
  - The `filter_len` port remains present but is ignored.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles with `in`=8'hFF → `level`, `pulse`, `pending` and `irq` all read 0. After release with `rise_en`=8'hFF, `filter_len`=0 and `SYNC_STAGES`=2 → `pulse`=8'hFF for exactly one cycle, 3 edges after release.
- **Rise/fall modes:** on ch0 set `rise_en`=1, `fall_en`=0; on ch1 set both; on ch2 set neither. Toggle `in[2:0]` 0→1→0 → ch0 pulses once, ch1 pulses twice, ch2 never pulses. `level` tracks the input on all three.
- **Glitch filter** (`EDGE_CAPTURE_FILTER_EN`, `filter_len`=3):
  - a 3-cycle high glitch on `in[0]` → `level[0]` stays 0, no pulse;
  - a 4-cycle high on `in[0]` → `level[0]` rises after edge k+2+3, then a single pulse.
- **Set/clear collision:** assert `clear[3]`=1 on the same cycle `pulse[3]`=1 → `pending[3]`=1 afterwards. Assert `clear[3]` one cycle later → `pending[3]`=0.
- **Interrupt masking:** set `pending`=8'h05 and `irq_mask`=8'h02 → `irq`=0. Change `irq_mask` to 8'h04 → `irq`=1 one cycle later. Clear ch2 → `irq`=0 while `pending`=8'h01.
- **Mode change with no edge:** toggle `rise_en[4]` 0→1 while `level[4]`=1 is stable → no pulse. Reset mid-filter-count → `cnt` and `level` return to 0, and no pulse follows the reset.
